// File: rtl/soc_single.sv
// soc_single: single-cycle RV32I-subset core with imem, dmem and result/flag MMIO.
// Define HALT_ON_FLAG_EN to freeze the core once the flag register is non-zero.

module soc_single_imem #(
   parameter int WORDS = 256
) (
   input  logic [$clog2(WORDS)-1:0] idx_i,
   output logic [31:0]              data_o
);
   logic [31:0] mem [0:WORDS-1];

   assign data_o = mem[idx_i];
endmodule

module soc_single #(
   parameter int          IMEM_WORDS  = 256,
   parameter int          DMEM_WORDS  = 256,
   parameter logic [31:0] RESULT_ADDR = 32'h0000_0000,
   parameter logic [31:0] FLAG_ADDR   = 32'h0000_0004
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        fetch_enable_i,
   output logic [31:0] mem_flag_o,
   output logic [31:0] mem_result_o,
   output logic [31:0] instr_addr_o
);
   localparam int IAW = $clog2(IMEM_WORDS);
   localparam int DAW = $clog2(DMEM_WORDS);

   localparam logic [6:0] OP_LUI   = 7'h37;
   localparam logic [6:0] OP_AUIPC = 7'h17;
   localparam logic [6:0] OP_JAL   = 7'h6F;
   localparam logic [6:0] OP_JALR  = 7'h67;
   localparam logic [6:0] OP_BR    = 7'h63;
   localparam logic [6:0] OP_LD    = 7'h03;
   localparam logic [6:0] OP_ST    = 7'h23;
   localparam logic [6:0] OP_IMM   = 7'h13;
   localparam logic [6:0] OP_REG   = 7'h33;

   logic [31:0] pc_q, pc_d, pc4;
   logic [31:0] regs_q [0:31];
   logic [31:0] result_q, flag_q;
   logic [31:0] dmem [0:DMEM_WORDS-1];

   logic [31:0] instr;
   logic [6:0]  opcode, f7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_v, rs2_v;
   logic [31:0] ld_addr, st_addr, ld_val;
   logic [31:0] alu_b, alu_res;
   logic        alu_sub, reg_ok, imm_ok, br_take;
   logic        wb_en, st_en, run;
   logic [31:0] wb_val;

   soc_single_imem #(.WORDS(IMEM_WORDS)) inst_mem (
      .idx_i  (pc_q[IAW+1:2]),
      .data_o (instr)
   );

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign f3     = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign f7     = instr[31:25];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                   instr[20], instr[30:21], 1'b0};

   assign rs1_v = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
   assign rs2_v = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];

   assign pc4     = pc_q + 32'd4;
   assign ld_addr = rs1_v + imm_i;
   assign st_addr = rs1_v + imm_s;

   assign instr_addr_o = pc_q;
   assign mem_result_o = result_q;
   assign mem_flag_o   = flag_q;

`ifdef HALT_ON_FLAG_EN
   assign run = fetch_enable_i & (flag_q == 32'd0);
`else
   assign run = fetch_enable_i;
`endif

   // MMIO registers shadow dmem for loads at their exact byte addresses
   always_comb begin
      ld_val = dmem[ld_addr[DAW+1:2]];
      if (ld_addr == RESULT_ADDR)
         ld_val = result_q;
      else if (ld_addr == FLAG_ADDR)
         ld_val = flag_q;
   end

   always_comb begin
      alu_b   = (opcode == OP_REG) ? rs2_v : imm_i;
      alu_sub = (opcode == OP_REG) & f7[5];
      alu_res = 32'd0;
      case (f3)
         3'd0: alu_res = alu_sub ? rs1_v - alu_b : rs1_v + alu_b;
         3'd1: alu_res = rs1_v << alu_b[4:0];
         3'd2: alu_res = {31'd0, $signed(rs1_v) < $signed(alu_b)};
         3'd3: alu_res = {31'd0, rs1_v < alu_b};
         3'd4: alu_res = rs1_v ^ alu_b;
         3'd5: alu_res = f7[5] ? 32'($signed(rs1_v) >>> alu_b[4:0])
                               : rs1_v >> alu_b[4:0];
         3'd6: alu_res = rs1_v | alu_b;
         default: alu_res = rs1_v & alu_b;
      endcase
   end

   assign reg_ok = (f7 == 7'h00) ||
                   ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
   assign imm_ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                   (f3 == 3'd5) ? ((f7 == 7'h00) || (f7 == 7'h20)) : 1'b1;

   always_comb begin
      br_take = 1'b0;
      case (f3)
         3'd0: br_take = rs1_v == rs2_v;
         3'd1: br_take = rs1_v != rs2_v;
         3'd4: br_take = $signed(rs1_v) < $signed(rs2_v);
         3'd5: br_take = $signed(rs1_v) >= $signed(rs2_v);
         3'd6: br_take = rs1_v < rs2_v;
         3'd7: br_take = rs1_v >= rs2_v;
         default: br_take = 1'b0;
      endcase
   end

   // Anything not decoded below retires as a NOP
   always_comb begin
      pc_d   = pc4;
      wb_en  = 1'b0;
      wb_val = 32'd0;
      st_en  = 1'b0;
      case (opcode)
         OP_LUI: begin
            wb_en  = 1'b1;
            wb_val = imm_u;
         end
         OP_AUIPC: begin
            wb_en  = 1'b1;
            wb_val = pc_q + imm_u;
         end
         OP_JAL: begin
            wb_en  = 1'b1;
            wb_val = pc4;
            pc_d   = pc_q + imm_j;
         end
         OP_JALR: if (f3 == 3'd0) begin
            wb_en  = 1'b1;
            wb_val = pc4;
            pc_d   = ld_addr & ~32'd1;
         end
         OP_BR: if (br_take) pc_d = pc_q + imm_b;
         OP_LD: if (f3 == 3'd2) begin
            wb_en  = 1'b1;
            wb_val = ld_val;
         end
         OP_ST: st_en = (f3 == 3'd2);
         OP_IMM: begin
            wb_en  = imm_ok;
            wb_val = alu_res;
         end
         OP_REG: begin
            wb_en  = reg_ok;
            wb_val = alu_res;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q     <= 32'd0;
         result_q <= 32'd0;
         flag_q   <= 32'd0;
         for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
      end else if (run) begin
         pc_q <= pc_d;
         if (wb_en && (rd != 5'd0)) regs_q[rd] <= wb_val;
         if (st_en && (st_addr == RESULT_ADDR)) result_q <= rs2_v;
         if (st_en && (st_addr == FLAG_ADDR))   flag_q   <= rs2_v;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && run && st_en &&
          (st_addr != RESULT_ADDR) && (st_addr != FLAG_ADDR))
         dmem[st_addr[DAW+1:2]] <= rs2_v;
   end
endmodule

// File: tb/tb_soc_single.sv
// tb_soc_single: directed program-level tests for soc_single.
// Programs are preloaded into inst_mem.mem while reset is held.

module tb_soc_single;
   logic        clk_i;
   logic        rst_i;
   logic        fetch_enable_i;
   logic [31:0] mem_flag_o;
   logic [31:0] mem_result_o;
   logic [31:0] instr_addr_o;

   int checks = 0;
   int errors = 0;

   soc_single dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .fetch_enable_i (fetch_enable_i),
      .mem_flag_o     (mem_flag_o),
      .mem_result_o   (mem_result_o),
      .instr_addr_o   (instr_addr_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [6:0] f7,
      input logic [4:0] rs2, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_i(input logic [6:0] op,
      input logic [4:0] rd, input logic [2:0] f3,
      input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm,
      input logic [4:0] rs2, input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm,
      input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] imm,
      input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
   endfunction

   function automatic logic [31:0] enc_u(input logic [6:0] op,
      input logic [4:0] rd, input logic [19:0] imm);
      return {imm, rd, op};
   endfunction

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) dut.inst_mem.mem[i] = 32'd0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic wait_flag(input string tag);
      int n;
      n = 0;
      while ((mem_flag_o == 32'd0) && (n < 1000)) begin
         @(negedge clk_i);
         n++;
      end
      chk({tag, "_done"}, {31'd0, mem_flag_o != 32'd0}, 32'd1);
   endtask

   task automatic load_fib();
      clear_imem();
      dut.inst_mem.mem[0]  = enc_i(7'h13, 5'd1, 3'd0, 5'd0, 12'd0);
      dut.inst_mem.mem[1]  = enc_i(7'h13, 5'd2, 3'd0, 5'd0, 12'd1);
      dut.inst_mem.mem[2]  = enc_i(7'h13, 5'd3, 3'd0, 5'd0, 12'd10);
      dut.inst_mem.mem[3]  = enc_i(7'h13, 5'd5, 3'd0, 5'd0, 12'h040);
      dut.inst_mem.mem[4]  = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd4);
      dut.inst_mem.mem[5]  = enc_s(12'd0, 5'd2, 5'd5);
      dut.inst_mem.mem[6]  = enc_i(7'h03, 5'd1, 3'd2, 5'd5, 12'd0);
      dut.inst_mem.mem[7]  = enc_i(7'h13, 5'd2, 3'd0, 5'd4, 12'd0);
      dut.inst_mem.mem[8]  = enc_i(7'h13, 5'd3, 3'd0, 5'd3, 12'hFFF);
      dut.inst_mem.mem[9]  = enc_b(13'h1FEC, 5'd0, 5'd3, 3'd1);
      dut.inst_mem.mem[10] = enc_s(12'd0, 5'd1, 5'd0);
      dut.inst_mem.mem[11] = enc_i(7'h13, 5'd6, 3'd0, 5'd0, 12'd1);
      dut.inst_mem.mem[12] = enc_s(12'd4, 5'd6, 5'd0);
      dut.inst_mem.mem[13] = enc_j(21'd0, 5'd0);
   endtask

   logic [31:0] pc_exp [14];
   logic [31:0] av [17];
   logic [31:0] ae [17];

   initial begin
      rst_i          = 1'b1;
      fetch_enable_i = 1'b0;

      // empty imem: every word retires as a NOP
      clear_imem();
      fetch_enable_i = 1'b1;
      do_reset();
      chk("rst_pc", instr_addr_o, 32'd0);
      chk("rst_res", mem_result_o, 32'd0);
      chk("rst_flag", mem_flag_o, 32'd0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk_i);
         chk($sformatf("nop_pc%0d", k), instr_addr_o, 32'(4 * k));
      end
      chk("nop_res", mem_result_o, 32'd0);
      chk("nop_flag", mem_flag_o, 32'd0);

      // fetch enable held low after reset
      fetch_enable_i = 1'b0;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         chk($sformatf("hold_pc%0d", k), instr_addr_o, 32'd0);
      end
      fetch_enable_i = 1'b1;
      @(negedge clk_i);
      chk("go_pc1", instr_addr_o, 32'd4);
      @(negedge clk_i);
      chk("go_pc2", instr_addr_o, 32'd8);

      // short program: result 4, then flag 1
      fetch_enable_i = 1'b0;
      rst_i = 1'b1;
      clear_imem();
      dut.inst_mem.mem[0] = enc_i(7'h13, 5'd1, 3'd0, 5'd0, 12'd7);
      dut.inst_mem.mem[1] = enc_i(7'h13, 5'd2, 3'd0, 5'd0, 12'hFFD);
      dut.inst_mem.mem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
      dut.inst_mem.mem[3] = enc_s(12'd0, 5'd3, 5'd0);
      dut.inst_mem.mem[4] = enc_i(7'h13, 5'd4, 3'd0, 5'd0, 12'd1);
      dut.inst_mem.mem[5] = enc_s(12'd4, 5'd4, 5'd0);
      dut.inst_mem.mem[6] = enc_j(21'd0, 5'd0);
      fetch_enable_i = 1'b1;
      do_reset();
      repeat (3) @(negedge clk_i);
      chk("p1_res3", mem_result_o, 32'd0);
      @(negedge clk_i);
      chk("p1_res4", mem_result_o, 32'd4);
      @(negedge clk_i);
      chk("p1_flag5", mem_flag_o, 32'd0);
      @(negedge clk_i);
      chk("p1_flag6", mem_flag_o, 32'd1);
      repeat (3) @(negedge clk_i);
      chk("p1_loop_pc", instr_addr_o, 32'd24);
      chk("p1_res_hold", mem_result_o, 32'd4);

      // branch / jump PC trace
      rst_i = 1'b1;
      clear_imem();
      dut.inst_mem.mem[0]  = enc_i(7'h13, 5'd1, 3'd0, 5'd0, 12'd5);
      dut.inst_mem.mem[1]  = enc_b(13'd8, 5'd0, 5'd1, 3'd0);
      dut.inst_mem.mem[2]  = enc_b(13'd8, 5'd1, 5'd1, 3'd0);
      dut.inst_mem.mem[3]  = enc_i(7'h13, 5'd9, 3'd0, 5'd0, 12'd99);
      dut.inst_mem.mem[4]  = enc_j(21'd8, 5'd2);
      dut.inst_mem.mem[5]  = enc_i(7'h13, 5'd9, 3'd0, 5'd0, 12'd99);
      dut.inst_mem.mem[6]  = enc_i(7'h13, 5'd3, 3'd0, 5'd2, 12'd13);
      dut.inst_mem.mem[7]  = enc_i(7'h67, 5'd4, 3'd0, 5'd3, 12'd0);
      dut.inst_mem.mem[8]  = enc_i(7'h13, 5'd0, 3'd0, 5'd0, 12'd77);
      dut.inst_mem.mem[9]  = enc_r(7'h00, 5'd4, 5'd2, 3'd0, 5'd5);
      dut.inst_mem.mem[10] = enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd5);
      dut.inst_mem.mem[11] = enc_r(7'h00, 5'd9, 5'd5, 3'd0, 5'd5);
      dut.inst_mem.mem[12] = enc_s(12'd0, 5'd5, 5'd0);
      dut.inst_mem.mem[13] = enc_s(12'd4, 5'd1, 5'd0);
      dut.inst_mem.mem[14] = enc_j(21'd0, 5'd0);
      pc_exp = '{32'd0, 32'd4, 32'd8, 32'd16, 32'd24, 32'd28, 32'd32,
                 32'd36, 32'd40, 32'd44, 32'd48, 32'd52, 32'd56, 32'd56};
      do_reset();
      for (int k = 0; k < 14; k++) begin
         if (k > 0) @(negedge clk_i);
         chk($sformatf("br_pc%0d", k), instr_addr_o, pc_exp[k]);
      end
      chk("br_res", mem_result_o, 32'd52);
      chk("br_flag", mem_flag_o, 32'd5);

      // ALU / LUI / AUIPC / LW-MMIO, each result stored to RESULT_ADDR
      av[0]  = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd10); ae[0]  = 32'hFFFF_FFF5;
      av[1]  = enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd10); ae[1]  = 32'hFFFF_FFFF;
      av[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd10); ae[2]  = 32'h1FFF_FFFF;
      av[3]  = enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd10); ae[3]  = 32'hFFFF_FFC0;
      av[4]  = enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd10); ae[4]  = 32'd1;
      av[5]  = enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd10); ae[5]  = 32'd0;
      av[6]  = enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd10); ae[6]  = 32'hFFFF_FFFB;
      av[7]  = enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd10); ae[7]  = 32'd0;
      av[8]  = enc_i(7'h13, 5'd10, 3'd5, 5'd1, 12'h401); ae[8] = 32'hFFFF_FFFC;
      av[9]  = enc_i(7'h13, 5'd10, 3'd3, 5'd2, 12'hFFF); ae[9] = 32'd1;
      av[10] = enc_i(7'h13, 5'd10, 3'd4, 5'd1, 12'hFFF); ae[10] = 32'd7;
      av[11] = enc_i(7'h13, 5'd10, 3'd7, 5'd1, 12'd15);  ae[11] = 32'd8;
      av[12] = enc_u(7'h37, 5'd10, 20'h12345);           ae[12] = 32'h1234_5000;
      av[13] = enc_i(7'h03, 5'd10, 3'd2, 5'd0, 12'd0);   ae[13] = 32'h1234_5000;
      av[14] = enc_u(7'h17, 5'd10, 20'h00001);           ae[14] = 32'h0000_1078;
      av[15] = enc_i(7'h13, 5'd10, 3'd2, 5'd1, 12'hFF9); ae[15] = 32'd1;
      av[16] = enc_i(7'h13, 5'd10, 3'd6, 5'd2, 12'd8);   ae[16] = 32'd11;
      rst_i = 1'b1;
      clear_imem();
      dut.inst_mem.mem[0] = enc_i(7'h13, 5'd1, 3'd0, 5'd0, 12'hFF8);
      dut.inst_mem.mem[1] = enc_i(7'h13, 5'd2, 3'd0, 5'd0, 12'd3);
      for (int k = 0; k < 17; k++) begin
         dut.inst_mem.mem[2 + 2 * k] = av[k];
         dut.inst_mem.mem[3 + 2 * k] = enc_s(12'd0, 5'd10, 5'd0);
      end
      dut.inst_mem.mem[36] = enc_j(21'd0, 5'd0);
      do_reset();
      repeat (2) @(negedge clk_i);
      for (int k = 0; k < 17; k++) begin
         repeat (2) @(negedge clk_i);
         chk($sformatf("alu%0d", k), mem_result_o, ae[k]);
      end

      // Fibonacci, then asynchronous reset mid-run and rerun
      rst_i = 1'b1;
      load_fib();
      do_reset();
      wait_flag("fib");
      chk("fib_res", mem_result_o, 32'd55);
      chk("fib_flag", mem_flag_o, 32'd1);
      repeat (3) @(negedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      chk("arst_res", mem_result_o, 32'd0);
      chk("arst_flag", mem_flag_o, 32'd0);
      chk("arst_pc", instr_addr_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      wait_flag("rerun");
      chk("rerun_res", mem_result_o, 32'd55);
      chk("rerun_flag", mem_flag_o, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
